// File: rtl/service_sequencer.sv
// -----------------------------------------------------------------------------
// service_sequencer
//
// Top-level controller for the 4-digit mm:ss clock. Arbitrates which service
// owns the shared push buttons and the 7-segment display, chosen from the spdt
// switches (lowest index wins, no preemption once granted). Detects the alarm
// match and runs the ring sequence; any push dismisses the ring.
//
// Optional feature (macro SERVICE_SEQ_SNOOZE_EN): push_d alone during a ring
// snoozes it for SNOOZE_SECS seconds, after which the ring restarts.
//
// Parameters:
//   RING_SECS    seconds the ring lasts without dismissal (1..255)
//   SNOOZE_SECS  snooze delay in seconds, snooze build only (1..255)
//
// Ports:
//   clk        system clock
//   resetn     synchronous active-low reset
//   spdt[3:0]  service request switches, bit n requests service n
//   push_u/d/l/r  debounced one-cycle button pulses
//   tick_1hz   one-cycle pulse per second
//   cur_time   current time, BCD mm:ss
//   alarm      alarm time, BCD mm:ss
//   alarm_en   alarm armed
//   grant      one-hot owner of buttons/display (0 = none)
//   svc_push   routed pulses, [4n+3:4n] = {u,d,l,r} for service n
//   disp_src   display source: 0 clock, n service n, 3 ringing
//   ring       alarm sounding
// -----------------------------------------------------------------------------
module service_sequencer #(
  parameter int unsigned RING_SECS   = 30,
  parameter int unsigned SNOOZE_SECS = 60
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  spdt,
  input  logic        push_u,
  input  logic        push_d,
  input  logic        push_l,
  input  logic        push_r,
  input  logic        tick_1hz,
  input  logic [15:0] cur_time,
  input  logic [15:0] alarm,
  input  logic        alarm_en,
  output logic [3:0]  grant,
  output logic [15:0] svc_push,
  output logic [1:0]  disp_src,
  output logic        ring
);

  // Elaboration-time guard on the parameter ranges.
  if (RING_SECS < 1 || RING_SECS > 255 || SNOOZE_SECS < 1 || SNOOZE_SECS > 255) begin : g_bad_param
    $error("service_sequencer: RING_SECS/SNOOZE_SECS must be in 1..255");
  end

  localparam logic [7:0] RING_LIM = 8'(RING_SECS);

`ifdef SERVICE_SEQ_SNOOZE_EN
  localparam logic [7:0] SNOOZE_LIM = 8'(SNOOZE_SECS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SW     = 3'd1,
    ST_SVC    = 3'd2,
    ST_RING   = 3'd3,
    ST_SNOOZE = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SW   = 3'd1,
    ST_SVC  = 3'd2,
    ST_RING = 3'd3
  } state_t;
`endif

  state_t      state_q,    state_d;
  logic [3:0]  grant_q,    grant_d;
  logic [1:0]  owner_q,    owner_d;
  logic [15:0] svc_push_q, svc_push_d;
  logic [1:0]  disp_src_q, disp_src_d;
  logic        ring_q,     ring_d;
  logic        pend_q,     pend_d;
  logic [7:0]  ring_cnt_q, ring_cnt_d;
`ifdef SERVICE_SEQ_SNOOZE_EN
  logic [7:0]  snooze_cnt_q, snooze_cnt_d;
`endif

  logic [3:0] pushes;
  logic       any_push;
  logic       match;
  logic       req_valid;
  logic [1:0] req_idx;

  assign pushes   = {push_u, push_d, push_l, push_r};
  assign any_push = |pushes;
  assign match    = alarm_en & tick_1hz & (cur_time == alarm);
  assign req_valid = |spdt;

  // Lowest-index set request wins: scan downward so the last hit is the lowest.
  always_comb begin
    req_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (spdt[i]) req_idx = 2'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    pend_d     = pend_q;
    ring_cnt_d = ring_cnt_q;
    svc_push_d = '0;
`ifdef SERVICE_SEQ_SNOOZE_EN
    snooze_cnt_d = snooze_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // A pending or fresh alarm beats any service request.
        if (pend_q || match) begin
          state_d    = ST_RING;
          pend_d     = 1'b0;
          ring_cnt_d = 8'd0;
        end else if (req_valid) begin
          state_d = ST_SW;
          grant_d = 4'b0001 << req_idx;
          owner_d = req_idx;
        end
      end

      // Owner-switch guard cycle: pushes are dropped here.
      ST_SW: begin
        if (match) pend_d = 1'b1;
        state_d = ST_SVC;
      end

      ST_SVC: begin
        if (match) pend_d = 1'b1;
        if (!spdt[owner_q]) begin
          state_d = ST_IDLE;
          grant_d = 4'b0000;
        end else begin
          svc_push_d[{owner_q, 2'b00} +: 4] = pushes;
        end
      end

      ST_RING: begin
        // A push wins over a same-cycle tick and is consumed, never forwarded.
        if (any_push) begin
`ifdef SERVICE_SEQ_SNOOZE_EN
          if (pushes == 4'b0100) begin
            state_d      = ST_SNOOZE;
            snooze_cnt_d = 8'd0;
          end else begin
            state_d = ST_IDLE;
          end
`else
          state_d = ST_IDLE;
`endif
        end else if (ring_cnt_q == RING_LIM) begin
          state_d = ST_IDLE;
        end else if (tick_1hz) begin
          ring_cnt_d = ring_cnt_q + 8'd1;
        end
      end

`ifdef SERVICE_SEQ_SNOOZE_EN
      ST_SNOOZE: begin
        if (any_push) begin
          state_d = ST_IDLE;
        end else if (snooze_cnt_q == SNOOZE_LIM) begin
          state_d    = ST_RING;
          ring_cnt_d = 8'd0;
        end else if (tick_1hz) begin
          snooze_cnt_d = snooze_cnt_q + 8'd1;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
        grant_d = 4'b0000;
      end
    endcase

    // ring tracks the next state so the registered copy equals (state==RING).
    ring_d = (state_d == ST_RING);

    // disp_src follows the current state, so it lags the state by one cycle.
    case (state_q)
      ST_RING:       disp_src_d = 2'd3;
      ST_SW, ST_SVC: disp_src_d = owner_q;
      default:       disp_src_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      svc_push_q <= '0;
      disp_src_q <= '0;
      ring_q     <= 1'b0;
      pend_q     <= 1'b0;
      ring_cnt_q <= '0;
`ifdef SERVICE_SEQ_SNOOZE_EN
      snooze_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      svc_push_q <= svc_push_d;
      disp_src_q <= disp_src_d;
      ring_q     <= ring_d;
      pend_q     <= pend_d;
      ring_cnt_q <= ring_cnt_d;
`ifdef SERVICE_SEQ_SNOOZE_EN
      snooze_cnt_q <= snooze_cnt_d;
`endif
    end
  end

  assign grant    = grant_q;
  assign svc_push = svc_push_q;
  assign disp_src = disp_src_q;
  assign ring     = ring_q;

endmodule
